mult_pipe: RTL and testbench

MULT_PIPE -- requirements
Module: mult_pipe

---
 rtl/mult_pipe.sv | 135 +++++++++++++
 tb/tb_mult_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// mult_pipe: STAGES-deep shift-add multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready flow control and flush.
// Define MULT_PIPE_BMASK_EN to add per-op branch masks with squash/resolve.
module mult_pipe #(
    parameter int XLEN    = 32,
    parameter int STAGES  = 4,
    parameter int TAG_W   = 6,
    parameter int BMASK_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
`ifdef MULT_PIPE_BMASK_EN
    input  logic [BMASK_W-1:0] in_bmask,
    input  logic               br_squash,
    input  logic               br_resolve,
    input  logic [BMASK_W-1:0] br_bit,
    output logic [BMASK_W-1:0] out_bmask,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int W2 = 2 * XLEN;
    localparam int CH = W2 / STAGES;
    localparam int L  = STAGES - 1;

    logic             v_q     [STAGES];
    logic [1:0]       op_q    [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [W2-1:0]    sum_q   [STAGES];
    logic [W2-1:0]    mc_q    [STAGES];
    logic [W2-1:0]    mp_q    [STAGES];
    logic             src_v   [STAGES];
    logic [1:0]       src_op  [STAGES];
    logic [TAG_W-1:0] src_tag [STAGES];
    logic [W2-1:0]    src_sum [STAGES];
    logic [W2-1:0]    src_mc  [STAGES];
    logic [W2-1:0]    src_mp  [STAGES];
    logic [W2-1:0]    sum_d   [STAGES];
    logic             live_q  [STAGES];
    logic             live_s  [STAGES];
`ifdef MULT_PIPE_BMASK_EN
    logic [BMASK_W-1:0] bm_q   [STAGES];
    logic [BMASK_W-1:0] src_bm [STAGES];
`endif
    logic          stall;
    logic          accept;
    logic [W2-1:0] rs1_x;
    logic [W2-1:0] rs2_x;

    assign out_valid  = v_q[L] & ~flush;
    assign stall      = out_valid & ~out_ready;
    assign in_ready   = rst_n & ~stall & ~flush;
    assign accept     = in_valid & in_ready;
    assign out_result = (op_q[L] == 2'd0) ? sum_q[L][XLEN-1:0] : sum_q[L][W2-1:XLEN];
    assign out_tag    = tag_q[L];
`ifdef MULT_PIPE_BMASK_EN
    assign out_bmask  = bm_q[L];
`endif
    // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned
    assign rs1_x = {{XLEN{(in_op != 2'd3) && in_rs1[XLEN-1]}}, in_rs1};
    assign rs2_x = {{XLEN{!in_op[1] && in_rs2[XLEN-1]}}, in_rs2};

    always_comb begin
        src_v[0]   = accept;
        src_op[0]  = in_op;
        src_tag[0] = in_tag;
        src_sum[0] = '0;
        src_mc[0]  = rs1_x;
        src_mp[0]  = rs2_x;
`ifdef MULT_PIPE_BMASK_EN
        src_bm[0]  = in_bmask;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_op[k]  = op_q[k-1];
            src_tag[k] = tag_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_mc[k]  = mc_q[k-1];
            src_mp[k]  = mp_q[k-1];
`ifdef MULT_PIPE_BMASK_EN
            src_bm[k]  = bm_q[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = src_sum[k] + W2'(src_mp[k][CH-1:0]) * src_mc[k];
`ifdef MULT_PIPE_BMASK_EN
            live_q[k] = v_q[k] & ~(br_squash & |(bm_q[k] & br_bit));
            live_s[k] = src_v[k] & ~(br_squash & |(src_bm[k] & br_bit));
`else
            live_q[k] = v_q[k];
            live_s[k] = src_v[k];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) v_q[k] <= ~flush & (stall ? live_q[k] : live_s[k]);
        end
    end

`ifdef MULT_PIPE_BMASK_EN
    // squash and resolve must act on stored masks even while the pipe is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) bm_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                bm_q[k] <= (stall ? bm_q[k] : src_bm[k]) & ~(br_resolve ? br_bit : '0);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]  <= src_op[k];
                tag_q[k] <= src_tag[k];
                sum_q[k] <= sum_d[k];
                mc_q[k]  <= src_mc[k] << CH;
                mp_q[k]  <= src_mp[k] >> CH;
            end
        end
    end
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed and random checks of mult_pipe against a scoreboard built on plain integer multiplication.
module tb_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic [3:0]  in_bmask = '0;
    logic        br_squash = 1'b0;
    logic        br_resolve = 1'b0;
    logic [3:0]  br_bit = '0;
`ifdef MULT_PIPE_BMASK_EN
    logic [3:0]  out_bmask;
`endif

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        logic [3:0]  bm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] b2b_exp [4] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};

    mult_pipe #(.XLEN(32), .STAGES(4), .TAG_W(6), .BMASK_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .flush(flush),
`ifdef MULT_PIPE_BMASK_EN
        .in_bmask(in_bmask), .br_squash(br_squash), .br_resolve(br_resolve),
        .br_bit(br_bit), .out_bmask(out_bmask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] x, y, p;
        x = (op == 2'd3) ? $signed({34'd0, a}) : $signed({{34{a[31]}}, a});
        y = op[1] ? $signed({34'd0, b}) : $signed({{34{b[31]}}, b});
        p = x * y;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // scoreboard: consumes on handshake, drops on flush/reset/squash, appends on accept
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            q.delete();
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready) && !flush);
            if (flush) check("flush_out_valid", out_valid, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", out_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    check("sb_result", out_result, mon_e.res);
                    check("sb_tag", out_tag, mon_e.tag);
`ifdef MULT_PIPE_BMASK_EN
                    check("sb_bmask", out_bmask, mon_e.bm);
`endif
                end
            end
            if (flush) q.delete();
            if (br_squash)
                for (int i = q.size() - 1; i >= 0; i--) if (|(q[i].bm & br_bit)) q.delete(i);
            if (br_resolve)
                for (int i = 0; i < q.size(); i++) q[i].bm = q[i].bm & ~br_bit;
            if (in_valid && in_ready && !(br_squash && |(in_bmask & br_bit)))
                q.push_back('{ref_mul(in_op, in_rs1, in_rs2), in_tag,
                              br_resolve ? in_bmask & ~br_bit : in_bmask});
        end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = tag;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        @(posedge clk);
        #1 drive(op, a, b, tag);
    endtask

    task automatic idle();
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 16);
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic lat_test(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] tag, input logic [31:0] exp);
        int n;
        send(2'd0, a, b, tag);
        idle();
        wait_out(n);
        check({name, "_latency"}, n, 4);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, out_tag, tag);
    endtask

    initial begin
        int n, bad;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_tag = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);

        lat_test("mul_7x6", 32'd7, 32'd6, 6'd5, 32'h2A);

        send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1);
        send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2);
        send(2'd2, 32'hFFFFFFFF, 32'd2, 6'd3);
        send(2'd0, 32'h80000000, 32'd2, 6'd4);
        idle();
        wait_out(n);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b_valid", out_valid, 1);
            check("b2b_result", out_result, b2b_exp[i]);
            check("b2b_tag", out_tag, i + 1);
        end

        for (int i = 0; i < 4; i++) send(2'd0, i + 2, 32'd10, 6'(i + 1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        wait_out(n);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_result", out_result, 32'd20);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_valid", out_valid, 1);
            check("drain_result", out_result, (i + 2) * 10);
            check("drain_tag", out_tag, i + 1);
        end
        @(negedge clk);
        check("no_duplicate", out_valid, 0);

        for (int i = 0; i < 3; i++) send(2'd0, 32'd4, i + 1, 6'(10 + i));
        @(posedge clk);
        #1 drive(2'd0, 32'd5, 32'd5, 6'd13);
        flush = 1'b1;
        @(negedge clk);
        check("flush_same_cycle", out_valid, 0);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("flush_quiet", bad, 0);
        lat_test("mul_3x3", 32'd3, 32'd3, 6'd7, 32'd9);

        for (int i = 0; i < 5; i++) send(2'd3, 32'hFFFF0000 + i, 32'd3, 6'(20 + i));
        #1 check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1 check("reset_drop_valid", out_valid, 0);
        check("reset_drop_ready", in_ready, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rerelease", in_ready, 1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("no_stale_after_reset", bad, 0);

        repeat (400) begin
            @(posedge clk);
            #1 drive($urandom_range(0, 3), pick(), pick(), $urandom_range(0, 63));
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 39) == 0;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("random_drain_empty", q.size(), 0);

`ifdef MULT_PIPE_BMASK_EN
        @(posedge clk);
        #1 drive(2'd0, 32'd5, 32'd5, 6'd30);
        in_bmask = 4'b0001;
        @(posedge clk);
        #1 drive(2'd0, 32'd6, 32'd6, 6'd31);
        in_bmask = 4'b0010;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_bmask = '0;
        br_squash = 1'b1;
        br_bit = 4'b0001;
        @(posedge clk);
        #1 br_squash = 1'b0;
        br_resolve = 1'b1;
        br_bit = 4'b0010;
        @(posedge clk);
        #1 br_resolve = 1'b0;
        br_bit = '0;
        wait_out(n);
        check("bm_result", out_result, 32'd36);
        check("bm_tag", out_tag, 6'd31);
        check("bm_out_bmask", out_bmask, 4'b0000);
        @(negedge clk);
        check("bm_only_one", out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
